// File: rtl/mem_lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_lsu_pkg
// Description : Shared opcodes, funct3 size encodings and FSM states for the
//               load/store unit.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_DONE   = 2'b10
  } lsu_state_e;

  localparam logic [6:0] C_OP_LOAD  = 7'b0000011;
  localparam logic [6:0] C_OP_STORE = 7'b0100011;

  localparam logic [2:0] C_F3_B  = 3'b000;
  localparam logic [2:0] C_F3_H  = 3'b001;
  localparam logic [2:0] C_F3_W  = 3'b010;
  localparam logic [2:0] C_F3_BU = 3'b100;
  localparam logic [2:0] C_F3_HU = 3'b101;

  localparam logic [1:0] C_SZ_B = 2'b00;
  localparam logic [1:0] C_SZ_H = 2'b01;
  localparam logic [1:0] C_SZ_W = 2'b10;

  // Legal funct3 for the access kind and natural alignment of the address.
  function automatic logic access_ok(input logic       is_store,
                                     input logic [2:0] f3,
                                     input logic [1:0] addr_lo);
    logic legal;
    logic aligned;
    if (is_store) begin
      legal = (f3 == C_F3_B) || (f3 == C_F3_H) || (f3 == C_F3_W);
    end else begin
      legal = (f3 == C_F3_B) || (f3 == C_F3_H) || (f3 == C_F3_W) ||
              (f3 == C_F3_BU) || (f3 == C_F3_HU);
    end
    case (f3[1:0])
      C_SZ_H:  aligned = ~addr_lo[0];
      C_SZ_W:  aligned = (addr_lo == 2'b00);
      default: aligned = 1'b1;
    endcase
    return legal && aligned;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lsu_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_lsu_if
// Description : Single-outstanding memory bus between the LSU and memory.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_lsu_if;

  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req,
    output bus_we,
    output bus_addr,
    output bus_wstrb,
    output bus_wdata,
    input  bus_ack,
    input  bus_rdata
  );

  modport slave (
    input  bus_req,
    input  bus_we,
    input  bus_addr,
    input  bus_wstrb,
    input  bus_wdata,
    output bus_ack,
    output bus_rdata
  );

endinterface
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_align
// Description : Byte-lane store placement and load extraction/extension.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_align
  import mem_lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    wstrb = 4'b0000;
    wdata = 32'h0;
    case (funct3[1:0])
      C_SZ_B: begin
        wstrb = 4'b0001 << addr_lo;
        wdata = {4{store_data[7:0]}};
      end
      C_SZ_H: begin
        wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata = {2{store_data[15:0]}};
      end
      default: begin
        wstrb = 4'b1111;
        wdata = store_data;
      end
    endcase
  end

  always_comb begin
    w_byte = 8'h0;
    case (addr_lo)
      2'b00:   w_byte = rdata[7:0];
      2'b01:   w_byte = rdata[15:8];
      2'b10:   w_byte = rdata[23:16];
      default: w_byte = rdata[31:24];
    endcase
    w_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    load_data = rdata;
    case (funct3)
      C_F3_B:  load_data = {{24{w_byte[7]}}, w_byte};
      C_F3_BU: load_data = {24'h0, w_byte};
      C_F3_H:  load_data = {{16{w_half[15]}}, w_half};
      C_F3_HU: load_data = {16'h0, w_half};
      default: load_data = rdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_lsu.sv
`default_nettype none
// ============================================================================
// Module      : mem_lsu
// Description : Load/store unit: one blocking bus access per memory op, with
//               writeback, misalignment/illegal-size checks and bus timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int unsigned BUS_TIMEOUT = 255,
  parameter logic [6:0]  LOAD_OP     = C_OP_LOAD,
  parameter logic [6:0]  STORE_OP    = C_OP_STORE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [6:0]  operation,
  input  logic [2:0]  funct3,
  input  logic [31:0] data_alu,
  input  logic [31:0] addr_mem,
  input  logic [31:0] data_rs2,
  mem_lsu_if.master   bus,
  output logic        stall,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic        lsu_err
);

  localparam int unsigned         C_CNT_W    = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;
  localparam logic [C_CNT_W-1:0]  C_CNT_LAST = C_CNT_W'(BUS_TIMEOUT - 1);

  lsu_state_e          r_state;
  logic [C_CNT_W-1:0]  r_cnt;
  logic                r_is_load;
  logic [2:0]          r_f3;
  logic [1:0]          r_addr_lo;

  logic        w_is_load;
  logic        w_is_store;
  logic        w_is_mem;
  logic        w_ok;
  logic        w_accept;
  logic [2:0]  w_lane_f3;
  logic [1:0]  w_lane_lo;
  logic [3:0]  w_wstrb;
  logic [31:0] w_wdata;
  logic [31:0] w_load_data;

  assign w_is_load  = (operation == LOAD_OP);
  assign w_is_store = (operation == STORE_OP);
  assign w_is_mem   = w_is_load || w_is_store;
  assign w_ok       = access_ok(w_is_store, funct3, addr_mem[1:0]);
  assign w_accept   = (r_state == ST_IDLE) && ex_valid && w_is_mem && w_ok;

  // Stall must rise in the accept cycle itself, so it cannot be registered.
  assign stall = !rst && (w_accept || (r_state == ST_ACCESS));

  // Store placement uses live inputs at accept; extraction uses latched fields.
  assign w_lane_f3 = (r_state == ST_IDLE) ? funct3        : r_f3;
  assign w_lane_lo = (r_state == ST_IDLE) ? addr_mem[1:0] : r_addr_lo;

  lsu_align u_align (
    .funct3     (w_lane_f3),
    .addr_lo    (w_lane_lo),
    .store_data (data_rs2),
    .rdata      (bus.bus_rdata),
    .wstrb      (w_wstrb),
    .wdata      (w_wdata),
    .load_data  (w_load_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_is_load     <= 1'b0;
      r_f3          <= 3'b000;
      r_addr_lo     <= 2'b00;
      bus.bus_req   <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= 32'h0;
      bus.bus_wstrb <= 4'b0000;
      bus.bus_wdata <= 32'h0;
      wb_valid      <= 1'b0;
      wb_data       <= 32'h0;
      lsu_err       <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      lsu_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (ex_valid) begin
            if (!w_is_mem) begin
              wb_data  <= data_alu;
              wb_valid <= 1'b1;
            end else if (w_ok) begin
              r_state       <= ST_ACCESS;
              r_cnt         <= '0;
              r_is_load     <= w_is_load;
              r_f3          <= funct3;
              r_addr_lo     <= addr_mem[1:0];
              bus.bus_req   <= 1'b1;
              bus.bus_we    <= w_is_store;
              bus.bus_addr  <= {addr_mem[31:2], 2'b00};
              bus.bus_wstrb <= w_is_store ? w_wstrb : 4'b0000;
              bus.bus_wdata <= w_is_store ? w_wdata : 32'h0;
            end else begin
              lsu_err <= 1'b1;
            end
          end
        end
        ST_ACCESS: begin
          if (bus.bus_ack) begin
            bus.bus_req <= 1'b0;
            r_state     <= ST_DONE;
            if (r_is_load) begin
              wb_data  <= w_load_data;
              wb_valid <= 1'b1;
            end
          end else if (r_cnt == C_CNT_LAST) begin
            bus.bus_req <= 1'b0;
            lsu_err     <= 1'b1;
            r_state     <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + C_CNT_W'(1);
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state     <= ST_IDLE;
          bus.bus_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_lsu.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_lsu
// Description : Self-checking bench for mem_lsu against a transaction model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mem_lsu;

  localparam int          TO       = 4;
  localparam logic [6:0]  OP_LOAD  = 7'b0000011;
  localparam logic [6:0]  OP_STORE = 7'b0100011;
  localparam logic [6:0]  OP_ADD   = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0;
  logic [6:0]  operation = 7'h0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] data_alu = 32'h0;
  logic [31:0] addr_mem = 32'h0;
  logic [31:0] data_rs2 = 32'h0;
  logic        stall;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic        lsu_err;

  mem_lsu_if bus_if ();

  mem_lsu #(.BUS_TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .ex_valid  (ex_valid),
    .operation (operation),
    .funct3    (funct3),
    .data_alu  (data_alu),
    .addr_mem  (addr_mem),
    .data_rs2  (data_rs2),
    .bus       (bus_if),
    .stall     (stall),
    .wb_valid  (wb_valid),
    .wb_data   (wb_data),
    .lsu_err   (lsu_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] bus_mem [256];
  logic [31:0] ref_mem [256];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit model_legal(bit is_st, logic [2:0] f3, logic [31:0] a);
    int n;
    if (is_st) begin
      if (!(f3 inside {3'd0, 3'd1, 3'd2})) return 1'b0;
    end else begin
      if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
    end
    n = 1 << f3[1:0];
    return (int'(a[1:0]) % n) == 0;
  endfunction

  function automatic logic [3:0] model_strb(logic [2:0] f3, logic [31:0] a);
    int n;
    int off;
    logic [3:0] s;
    n   = 1 << f3[1:0];
    off = int'(a[1:0]);
    s   = 4'b0000;
    for (int i = 0; i < 4; i++) if (i >= off && i < off + n) s[i] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] model_wdata(logic [2:0] f3, logic [31:0] rs2);
    int n;
    logic [31:0] w;
    n = 1 << f3[1:0];
    w = 32'h0;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = rs2[8*(i % n) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] model_load(logic [31:0] word, logic [2:0] f3, logic [31:0] a);
    int     n;
    int     off;
    longint v;
    longint mask;
    n    = 1 << f3[1:0];
    off  = int'(a[1:0]);
    mask = (longint'(1) << (8*n)) - 1;
    v    = (longint'({32'h0, word}) >> (8*off)) & mask;
    if (!f3[2] && n < 4 && v[8*n-1]) v = v | ~mask;
    return v[31:0];
  endfunction

  task automatic do_op(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] rs2, input logic [31:0] alu, input int ack_dly);
    bit is_ld;
    bit is_st;
    bit ok;
    bit acked;
    int n_stall;
    int n_req;
    int idx;
    int off;
    logic [3:0] s;
    is_ld = (op == OP_LOAD);
    is_st = (op == OP_STORE);
    ok    = (is_ld || is_st) && model_legal(is_st, f3, a);
    acked = 1'b0;
    idx   = int'(a[9:2]);
    tick();
    ex_valid  = 1'b1;
    operation = op;
    funct3    = f3;
    addr_mem  = a;
    data_rs2  = rs2;
    data_alu  = alu;
    bus_if.bus_ack   = 1'($urandom_range(0, 1));
    bus_if.bus_rdata = $urandom;
    #1;
    check_eq("stall_accept", stall, ok);
    n_stall = stall ? 1 : 0;
    if (!ok) begin
      tick();
      ex_valid = 1'b0;
      bus_if.bus_ack = 1'b0;
      #1;
      check_eq("bus_req_none", bus_if.bus_req, 0);
      check_eq("stall_after", stall, 0);
      if (is_ld || is_st) begin
        check_eq("err_pulse", lsu_err, 1);
        check_eq("err_no_wb", wb_valid, 0);
      end else begin
        check_eq("alu_wb_valid", wb_valid, 1);
        check_eq("alu_wb_data", wb_data, alu);
        check_eq("alu_no_err", lsu_err, 0);
      end
      return;
    end
    n_req = 0;
    for (int k = 0; k < TO; k++) begin
      tick();
      bus_if.bus_ack   = (k == ack_dly);
      bus_if.bus_rdata = bus_if.bus_ack ? bus_mem[idx] : $urandom;
      #1;
      check_eq("bus_req", bus_if.bus_req, 1);
      check_eq("bus_we", bus_if.bus_we, is_st);
      check_eq("bus_addr", bus_if.bus_addr, {a[31:2], 2'b00});
      if (is_st) begin
        check_eq("bus_wstrb", bus_if.bus_wstrb, model_strb(f3, a));
        check_eq("bus_wdata", bus_if.bus_wdata, model_wdata(f3, rs2));
      end
      if (bus_if.bus_req) n_req++;
      if (stall) n_stall++;
      if (bus_if.bus_ack) begin
        acked = 1'b1;
        if (bus_if.bus_we)
          for (int i = 0; i < 4; i++)
            if (bus_if.bus_wstrb[i]) bus_mem[idx][8*i +: 8] = bus_if.bus_wdata[8*i +: 8];
        break;
      end
    end
    tick();
    ex_valid = 1'b0;
    bus_if.bus_ack = 1'b0;
    #1;
    check_eq("stall_cycles", n_stall, acked ? ack_dly + 2 : TO + 1);
    check_eq("req_cycles", n_req, acked ? ack_dly + 1 : TO);
    check_eq("req_dropped", bus_if.bus_req, 0);
    check_eq("stall_done", stall, 0);
    if (acked) begin
      check_eq("done_no_err", lsu_err, 0);
      check_eq("wb_valid_done", wb_valid, is_ld);
      if (is_ld) check_eq("load_data", wb_data, model_load(ref_mem[idx], f3, a));
      if (is_st) begin
        s   = model_strb(f3, a);
        off = int'(a[1:0]);
        for (int i = 0; i < 4; i++) if (s[i]) ref_mem[idx][8*i +: 8] = rs2[8*(i - off) +: 8];
      end
    end else begin
      check_eq("timeout_err", lsu_err, 1);
      check_eq("timeout_no_wb", wb_valid, 0);
    end
  endtask

  task automatic idle_gap();
    tick();
    ex_valid = 1'b0;
    bus_if.bus_ack = 1'($urandom_range(0, 1));
    #1;
    check_eq("idle_req", bus_if.bus_req, 0);
    check_eq("idle_wb", wb_valid, 0);
    check_eq("idle_err", lsu_err, 0);
    check_eq("idle_stall", stall, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required $finish");
    $fatal(1);
  end

  initial begin
    logic [6:0]  op;
    logic [31:0] a;
    for (int i = 0; i < 256; i++) begin
      bus_mem[i] = $urandom;
      ref_mem[i] = bus_mem[i];
    end
    bus_if.bus_ack   = 1'b0;
    bus_if.bus_rdata = 32'h0;

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_req", bus_if.bus_req, 0);
    check_eq("rst_we", bus_if.bus_we, 0);
    check_eq("rst_addr", bus_if.bus_addr, 0);
    check_eq("rst_wstrb", bus_if.bus_wstrb, 0);
    check_eq("rst_wdata", bus_if.bus_wdata, 0);
    check_eq("rst_stall", stall, 0);
    check_eq("rst_wb_valid", wb_valid, 0);
    check_eq("rst_wb_data", wb_data, 0);
    check_eq("rst_err", lsu_err, 0);
    #2 rst = 1'b0;

    do_op(OP_STORE, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 2);
    idle_gap();
    bus_mem[32'h103 >> 2] = 32'h80FF00AA;
    ref_mem[32'h103 >> 2] = 32'h80FF00AA;
    do_op(OP_LOAD, 3'b000, 32'h103, 32'h0, 32'h0, 0);
    check_eq("lb_literal", wb_data, 32'hFFFFFF80);
    idle_gap();
    do_op(OP_LOAD, 3'b100, 32'h103, 32'h0, 32'h0, 0);
    check_eq("lbu_literal", wb_data, 32'h00000080);
    idle_gap();
    do_op(OP_STORE, 3'b001, 32'h202, 32'h00001234, 32'h0, 1);
    idle_gap();
    do_op(OP_LOAD, 3'b010, 32'h101, 32'h0, 32'h0, 0);
    idle_gap();
    do_op(OP_LOAD, 3'b010, 32'h40, 32'h0, 32'h0, 100);
    idle_gap();

    tick();
    ex_valid  = 1'b1;
    operation = OP_LOAD;
    funct3    = 3'b010;
    addr_mem  = 32'h40;
    bus_if.bus_ack = 1'b0;
    tick();
    check_eq("pre_rst_req", bus_if.bus_req, 1);
    #2 rst = 1'b1;
    #1;
    check_eq("async_rst_req", bus_if.bus_req, 0);
    check_eq("async_rst_stall", stall, 0);
    tick();
    ex_valid = 1'b0;
    #1 rst = 1'b0;
    #1;
    check_eq("post_rst_wb", wb_valid, 0);
    check_eq("post_rst_err", lsu_err, 0);
    do_op(OP_ADD, 3'b000, 32'h0, 32'h0, 32'h5, 0);
    idle_gap();

    for (int t = 0; t < 300; t++) begin
      case ($urandom_range(0, 4))
        0: begin
          op = 7'($urandom);
          if (op == OP_LOAD || op == OP_STORE) op = OP_ADD;
        end
        1, 2: op = OP_LOAD;
        default: op = OP_STORE;
      endcase
      a = 32'($urandom_range(0, 1023));
      do_op(op, 3'($urandom_range(0, 7)), a, $urandom, $urandom, $urandom_range(0, 5));
      idle_gap();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
